// File: rtl/led_matrix_pkg.sv
// Shared types for the 8x8 frame bus: matrix geometry, packed frame type and scanner states.
// Imported by the frame generators and by the LED matrix scanner.
package led_matrix_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef logic [ROWS-1:0][COLS-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BLANK,
        DRIVE
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_pwm_gate.sv
// Brightness gate for one row of column data; compiled only when LED_SCAN_PWM_EN is defined.
// Columns pass while the dwell phase is at or below the brightness level, giving (bright+1)/16 duty.
`ifdef LED_SCAN_PWM_EN
module led_pwm_gate
    import led_matrix_pkg::*;
(
    input  logic [COLS-1:0] cols_i,
    input  logic [3:0]      phase_i,
    input  logic [3:0]      bright_i,
    output logic [COLS-1:0] cols_o
);

    assign cols_o = (phase_i <= bright_i) ? cols_i : '0;

endmodule
`endif

// File: rtl/led_matrix_scan.sv
// Row-multiplexed LED matrix scanner: captures a frame into a shadow buffer once per frame and
// drives one row at a time with blanking between rows. Optional PWM dimming under LED_SCAN_PWM_EN.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  frame_t          frame_in,
    input  logic            frame_valid,
`ifdef LED_SCAN_PWM_EN
    input  logic [3:0]      brightness,
`endif
    output logic            frame_ready,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_out,
    output logic            frame_start
);

    localparam int CNT_MAX = max_int(DWELL_CYCLES, BLANK_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int ROW_W   = $clog2(ROWS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    scan_state_t      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    frame_t           shadow_q, shadow_d;
    logic [ROWS-1:0]  row_sel_d;
    logic [COLS-1:0]  cols_full, cols_gated, col_d;

`ifdef LED_SCAN_PWM_EN
    logic [3:0] bright_q, bright_d;
`endif

    // NOTE: every signal gets its hold value first so no path through the case leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
`ifdef LED_SCAN_PWM_EN
        bright_d = bright_q;
`endif
        unique case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                // A missing frame simply redisplays the old shadow; the scan never waits.
                if (frame_valid) shadow_d = frame_in;
`ifdef LED_SCAN_PWM_EN
                bright_d = brightness;
`endif
                state_d = BLANK;
                row_d   = '0;
                cnt_d   = '0;
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = LOAD;
                    end else begin
                        state_d = BLANK;
                        row_d   = row_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    assign cols_full = shadow_d[row_d];

`ifdef LED_SCAN_PWM_EN
    led_pwm_gate u_pwm_gate (
        .cols_i   (cols_full),
        .phase_i  (cnt_d[3:0]),
        .bright_i (bright_d),
        .cols_o   (cols_gated)
    );
`else
    assign cols_gated = cols_full;
`endif

    assign row_sel_d = (state_d == DRIVE) ? (ROWS'(1) << row_d) : '0;
    assign col_d     = (state_d == DRIVE) ? cols_gated : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            // NOTE: the shadow frame is cleared on reset so a restart shows a dark matrix
            // rather than stale or undefined pixels.
            shadow_q    <= '0;
            frame_ready <= 1'b0;
            frame_start <= 1'b0;
            row_sel     <= '0;
            col_out     <= '0;
`ifdef LED_SCAN_PWM_EN
            bright_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            frame_ready <= (state_d == LOAD);
            frame_start <= (state_d == LOAD);
            row_sel     <= row_sel_d;
            col_out     <= col_d;
`ifdef LED_SCAN_PWM_EN
            bright_q    <= bright_d;
`endif
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan (DWELL=16, BLANK=2): randomized frames checked every
// cycle against a position-in-frame model, plus literal checks; PWM checks under LED_SCAN_PWM_EN.
module tb_led_matrix_scan;
    import led_matrix_pkg::*;

    localparam int DW     = 16;
    localparam int BL     = 2;
    localparam int SLOT   = BL + DW;
    localparam int PERIOD = 1 + ROWS * SLOT;

    logic            clk = 1'b0;
    logic            reset;
    frame_t          frame_in;
    logic            frame_valid;
    logic [3:0]      brightness;
    logic            frame_ready;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_out;
    logic            frame_start;

    int nchk = 0;
    int nerr = 0;

    // Model state: k = posedges since reset release, p = position inside the frame period.
    int          k = 0;
    int          p = -1;
    int          last_fs = -1;
    bit          m_load = 1'b0;
    frame_t      m_shadow = '0;
    logic [3:0]  m_bright = '0;
    logic [7:0]  exp_row, exp_col;
    logic        exp_lead;

    always #5 clk = ~clk;

    led_matrix_scan #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
`ifdef LED_SCAN_PWM_EN
        .brightness  (brightness),
`endif
        .frame_ready (frame_ready),
        .row_sel     (row_sel),
        .col_out     (col_out),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (k=%0d p=%0d t=%0t)", name, act, exp, k, p, $time);
        end
    endtask

    // One clock: latch the inputs seen at the edge, advance the model, compare all outputs.
    task automatic step();
        logic       pr, pv;
        frame_t     pf;
        logic [3:0] pb;
        int         q, row, off;
        pr = reset; pv = frame_valid; pf = frame_in; pb = brightness;
        @(posedge clk);
        #1;
        exp_row = '0; exp_col = '0; exp_lead = 1'b0;
        if (pr) begin
            k = 0; p = -1; m_load = 1'b0; m_shadow = '0; last_fs = -1;
        end else begin
            if (m_load && pv) m_shadow = pf;
            if (m_load) m_bright = pb;
            k++;
            p = (k - 1) % PERIOD;
            if (p == 0) begin
                exp_lead = 1'b1;
            end else begin
                q   = p - 1;
                row = q / SLOT;
                off = q % SLOT;
                if (off >= BL) begin
                    exp_row = 8'(1 << row);
                    exp_col = m_shadow[row];
`ifdef LED_SCAN_PWM_EN
                    if ((off - BL) > int'(m_bright)) exp_col = '0;
`endif
                end
            end
            m_load = (p == 0);
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) check("frame_period", 64'(k - last_fs), 64'(PERIOD));
                last_fs = k;
            end
        end
        check("row_sel", 64'(row_sel), 64'(exp_row));
        check("col_out", 64'(col_out), 64'(exp_col));
        check("frame_ready", 64'(frame_ready), 64'(exp_lead));
        check("frame_start", 64'(frame_start), 64'(exp_lead));
    endtask

    task automatic run_to_load();
        int n = 0;
        do begin
            step();
            n++;
        end while (p != 0 && n < 2 * PERIOD);
        if (p != 0) check("load_timeout", 64'(p), 64'(0));
    endtask

    task automatic randomize_inputs(input bit valid_random);
        frame_in    = {$urandom, $urandom};
        frame_valid = valid_random ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef LED_SCAN_PWM_EN
        brightness  = 4'($urandom_range(0, 15));
`endif
    endtask

    initial begin
        int on_cnt, n;
        reset       = 1'b1;
        frame_in    = '0;
        frame_valid = 1'b0;
        brightness  = 4'd15;

        // Reset held three cycles, then the first LOAD appears after the IDLE cycle.
        repeat (3) step();
        check("reset_row_sel", 64'(row_sel), 64'h0);
        check("reset_frame_ready", 64'(frame_ready), 64'h0);
        reset = 1'b0;
        frame_in[1] = 8'hC6;
        frame_valid = 1'b1;
        step();
        check("first_frame_ready", 64'(frame_ready), 64'h1);
        check("first_frame_start", 64'(frame_start), 64'h1);

        // One frame showing only row 1.
        on_cnt = 0;
        for (int i = 0; i < PERIOD - 1; i++) begin
            step();
            if (col_out != '0) on_cnt++;
            if (p == 1 + SLOT + BL) begin
                check("row1_row_sel", 64'(row_sel), 64'h02);
                check("row1_col_out", 64'(col_out), 64'hC6);
            end
        end
        check("row1_on_cycles", 64'(on_cnt), 64'(DW));

        // Frame data churns every cycle with valid held high, then with valid random.
        for (int i = 0; i < 3 * PERIOD; i++) begin
            randomize_inputs(1'b0);
            step();
        end
        for (int i = 0; i < 4 * PERIOD; i++) begin
            randomize_inputs(1'b1);
            step();
        end

        // No valid frame at LOAD: the previous shadow must repeat.
        frame_valid = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            frame_in = {$urandom, $urandom};
            step();
        end

        // Reset while row 4 is lit, then a frame with no new data must stay dark.
        frame_valid = 1'b1;
        n = 0;
        do begin
            randomize_inputs(1'b0);
            step();
            n++;
        end while (exp_row != 8'h10 && n < 2 * PERIOD);
        check("row4_reached", 64'(row_sel), 64'h10);
        reset = 1'b1;
        step();
        check("midscan_reset_row_sel", 64'(row_sel), 64'h0);
        check("midscan_reset_col_out", 64'(col_out), 64'h0);
        step();
        reset = 1'b0;
        frame_valid = 1'b0;
        on_cnt = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            if (col_out != '0) on_cnt++;
        end
        check("post_reset_dark", 64'(on_cnt), 64'h0);

`ifdef LED_SCAN_PWM_EN
        // Dimming: brightness 3 lights 4 of 16 dwell cycles, 15 lights all of them.
        frame_in    = '1;
        frame_valid = 1'b1;
        brightness  = 4'd3;
        run_to_load();
        on_cnt = 0;
        for (int i = 0; i < PERIOD - 1; i++) begin
            step();
            if (col_out != '0) on_cnt++;
        end
        check("pwm_b3_on_cycles", 64'(on_cnt), 64'(ROWS * 4));
        brightness = 4'd15;
        run_to_load();
        on_cnt = 0;
        for (int i = 0; i < PERIOD - 1; i++) begin
            step();
            if (col_out != '0) on_cnt++;
        end
        check("pwm_b15_on_cycles", 64'(on_cnt), 64'(ROWS * 16));
`endif

        for (int i = 0; i < 2 * PERIOD; i++) begin
            randomize_inputs(1'b1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
